// File: rtl/tbec_rsc_apb_initiator_if.sv
// Bundles the codeword stream, result stream and APB segment seen by the TBEC-RSC initiator.
// master = initiator side, slave = fabric plus decoder peripheral side.
interface tbec_rsc_apb_initiator_if;
   logic [31:0] cw_data;
   logic        cw_valid;
   logic        cw_ready;
   logic [15:0] dout_data;
   logic        dout_err;
   logic        dout_valid;
   logic        dout_ready;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      input  cw_data, cw_valid, dout_ready, PRDATA, PREADY, PSLVERR,
      output cw_ready, dout_data, dout_err, dout_valid,
             PADDR, PWDATA, PSEL, PENABLE, PWRITE
   );

   modport slave (
      output cw_data, cw_valid, dout_ready, PRDATA, PREADY, PSLVERR,
      input  cw_ready, dout_data, dout_err, dout_valid,
             PADDR, PWDATA, PSEL, PENABLE, PWRITE
   );
endinterface

// File: rtl/tbec_rsc_apb_initiator.sv
// APB initiator for the TBEC-RSC decoder: writes each codeword to the data register, reads the decoded word back.
// Optional access-phase timeout is enabled by defining TBEC_APB_TIMEOUT_EN.
module tbec_rsc_apb_initiator #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic                      PCLK,
   input logic                      PRESET,
   tbec_rsc_apb_initiator_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      WR_SETUP,
      WR_ACCESS,
      RD_SETUP,
      RD_ACCESS,
      OUT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic        psel_q, psel_d;
   logic        penable_q, penable_d;
   logic        pwrite_q, pwrite_d;
   logic [15:0] dout_data_q, dout_data_d;
   logic        dout_err_q, dout_err_d;
   logic        dout_valid_q, dout_valid_d;
   logic        tmo_hit;
   logic        prdata_unused;

   // A zero timeout would abort every access before the slave could answer.
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef TBEC_APB_TIMEOUT_EN
   localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TmoW-1:0] tmo_q, tmo_d;

   assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

   // Counts wait cycles of the current access; any other cycle clears it, so each state entry starts at zero.
   always_comb begin
      tmo_d = '0;
      if ((state_q == WR_ACCESS || state_q == RD_ACCESS) && !bus.PREADY && !tmo_hit) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // The decoder only drives the low half of PRDATA.
   assign prdata_unused = ^bus.PRDATA[31:16];

   assign bus.cw_ready   = (state_q == IDLE) & ~PRESET;
   assign bus.PADDR      = paddr_q;
   assign bus.PWDATA     = pwdata_q;
   assign bus.PSEL       = psel_q;
   assign bus.PENABLE    = penable_q;
   assign bus.PWRITE     = pwrite_q;
   assign bus.dout_data  = dout_data_q;
   assign bus.dout_err   = dout_err_q;
   assign bus.dout_valid = dout_valid_q;

   always_comb begin
      state_d      = state_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      pwrite_d     = pwrite_q;
      dout_data_d  = dout_data_q;
      dout_err_d   = dout_err_q;
      dout_valid_d = dout_valid_q;

      case (state_q)
         IDLE: begin
            if (bus.cw_valid) begin
               pwdata_d  = bus.cw_data;
               paddr_d   = BASE_ADDR;
               pwrite_d  = 1'b1;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = WR_SETUP;
            end
         end
         WR_SETUP: begin
            penable_d = 1'b1;
            state_d   = WR_ACCESS;
         end
         WR_ACCESS: begin
            // A failed write skips the read; otherwise the read follows with PSEL kept high.
            if (bus.PREADY && bus.PSLVERR) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               dout_err_d  = 1'b1;
               dout_data_d = '0;
               state_d     = OUT;
            end else if (bus.PREADY) begin
               pwrite_d  = 1'b0;
               penable_d = 1'b0;
               state_d   = RD_SETUP;
            end else if (tmo_hit) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               dout_err_d  = 1'b1;
               dout_data_d = '0;
               state_d     = OUT;
            end
         end
         RD_SETUP: begin
            penable_d = 1'b1;
            state_d   = RD_ACCESS;
         end
         RD_ACCESS: begin
            if (bus.PREADY) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               dout_data_d = bus.PSLVERR ? 16'h0000 : bus.PRDATA[15:0];
               dout_err_d  = bus.PSLVERR;
               state_d     = OUT;
            end else if (tmo_hit) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               dout_err_d  = 1'b1;
               dout_data_d = '0;
               state_d     = OUT;
            end
         end
         OUT: begin
            if (!dout_valid_q) begin
               dout_valid_d = 1'b1;
            end else if (bus.dout_ready) begin
               dout_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q      <= IDLE;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         dout_data_q  <= '0;
         dout_err_q   <= 1'b0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         dout_data_q  <= dout_data_d;
         dout_err_q   <= dout_err_d;
         dout_valid_q <= dout_valid_d;
      end
   end

endmodule
